// File: rtl/max_subtract_stage_if.sv
// ---------------------------------------------------------------------------------------------
// max_subtract_stage_if
//   Bundles the beat-level signals of max_subtract_stage. The clock and reset are not part of
//   this bundle. They stay plain module ports.
//
//   Signals (directions as seen by the stage, i.e. the slave modport):
//     i_en               in   1            pipeline advance enable; 0 holds every register
//     i_valid            in   1            beat valid
//     i_length_mode      in   4            segment mode of the beat
//     i_global_max       in   DW           max over all beats of a long sequence
//     i_max64_0          in   DW           max of lanes 0..63
//     i_max32_0/1        in   DW each      max of lanes 0..31 / 32..63
//     i_max16_0..3       in   DW each      max of lanes 16j..16j+15
//     i_in_flat          in   LANES*DW     lane k = i_in_flat[DW*k +: DW], signed Q6.10
//     o_valid            out  1            output beat valid
//     o_length_mode_byp  out  4            length mode aligned with o_diff_flat
//     o_diff_flat        out  LANES*DW     lane k = saturated x[k] - max, Q6.10
//     o_zero_mask        out  LANES        bit k = lane k clamped
//
//   Modports: master = producer/consumer side (testbench or upstream), slave = the stage.
// ---------------------------------------------------------------------------------------------
interface max_subtract_stage_if #(
    parameter int unsigned LANES = 64,
    parameter int unsigned DW    = 16
);
    logic                  i_en;
    logic                  i_valid;
    logic [3:0]            i_length_mode;
    logic [DW-1:0]         i_global_max;
    logic [DW-1:0]         i_max64_0;
    logic [DW-1:0]         i_max32_0;
    logic [DW-1:0]         i_max32_1;
    logic [DW-1:0]         i_max16_0;
    logic [DW-1:0]         i_max16_1;
    logic [DW-1:0]         i_max16_2;
    logic [DW-1:0]         i_max16_3;
    logic [LANES*DW-1:0]   i_in_flat;

    logic                  o_valid;
    logic [3:0]            o_length_mode_byp;
    logic [LANES*DW-1:0]   o_diff_flat;
    logic [LANES-1:0]      o_zero_mask;

    modport master (
        output i_en,
        output i_valid,
        output i_length_mode,
        output i_global_max,
        output i_max64_0,
        output i_max32_0,
        output i_max32_1,
        output i_max16_0,
        output i_max16_1,
        output i_max16_2,
        output i_max16_3,
        output i_in_flat,
        input  o_valid,
        input  o_length_mode_byp,
        input  o_diff_flat,
        input  o_zero_mask
    );

    modport slave (
        input  i_en,
        input  i_valid,
        input  i_length_mode,
        input  i_global_max,
        input  i_max64_0,
        input  i_max32_0,
        input  i_max32_1,
        input  i_max16_0,
        input  i_max16_1,
        input  i_max16_2,
        input  i_max16_3,
        input  i_in_flat,
        output o_valid,
        output o_length_mode_byp,
        output o_diff_flat,
        output o_zero_mask
    );
endinterface

// File: rtl/max_subtract_stage.sv
// ---------------------------------------------------------------------------------------------
// max_subtract_stage
//   Softmax stage that sits directly after the tree max unit. It subtracts the per-segment max
//   from each of the 64 signed Q6.10 lanes (d = x - max). The resulting exp arguments are
//   non-positive and range-safe.
//
//   Pipeline: stage 1 registers the lanes, the mode, the valid bit and the max selected for
//   each lane. Stage 2 registers the saturated difference. Both stages advance only while
//   i_en=1; with i_en=0 every register holds, including o_valid. A beat presented in cycle c
//   with i_en=1 appears on the outputs in cycle c+2. Each stall cycle adds one cycle. No
//   combinational path exists from any input to any output.
//
//   Max selection (per beat, from i_length_mode):
//     0 -> i_max64_0,  1 -> i_max32_{k/32},  2 -> i_max16_{k/16},  3..15 -> i_global_max
//
//   Ports:
//     i_clk    in  clock
//     i_rst_n  in  asynchronous active-low reset; clears every pipeline register
//     bus      max_subtract_stage_if.slave (beat inputs, diff/valid/mask outputs)
//
//   Configuration macro: MAXSUB_CLAMP_EN
//     defined   : after saturation, d < CLAMP_MIN becomes CLAMP_MIN and sets o_zero_mask[k]
//     undefined : saturation only, o_zero_mask tied to 0 (default build)
//
//   LANES is fixed at 64 by the max tree; the segment decode assumes it.
// ---------------------------------------------------------------------------------------------
module max_subtract_stage #(
    parameter int unsigned LANES     = 64,
    parameter int unsigned DW        = 16,
    parameter int          CLAMP_MIN = -16384
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    max_subtract_stage_if.slave   bus
);

    localparam int unsigned FW = LANES * DW;

    // Saturation bounds for a DW-bit two's complement result.
    localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

    // -----------------------------------------------------------------------------------------
    // Stage 1: per-lane max selection (next-state of the stage 1 max register)
    // -----------------------------------------------------------------------------------------
    logic [FW-1:0] max_sel;

    always_comb begin
        max_sel = '0;
        for (int k = 0; k < LANES; k++) begin
            case (bus.i_length_mode)
                4'd0: max_sel[k*DW +: DW] = bus.i_max64_0;
                4'd1: max_sel[k*DW +: DW] = (k < 32) ? bus.i_max32_0 : bus.i_max32_1;
                4'd2: begin
                    case (k / 16)
                        0:       max_sel[k*DW +: DW] = bus.i_max16_0;
                        1:       max_sel[k*DW +: DW] = bus.i_max16_1;
                        2:       max_sel[k*DW +: DW] = bus.i_max16_2;
                        default: max_sel[k*DW +: DW] = bus.i_max16_3;
                    endcase
                end
                default: max_sel[k*DW +: DW] = bus.i_global_max;
            endcase
        end
    end

    // -----------------------------------------------------------------------------------------
    // Stage 1 registers. Data loads even for bubbles; only the valid bit marks a real beat.
    // -----------------------------------------------------------------------------------------
    logic          s1_valid_q;
    logic [3:0]    s1_mode_q;
    logic [FW-1:0] s1_x_q;
    logic [FW-1:0] s1_max_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= '0;
            s1_x_q     <= '0;
            s1_max_q   <= '0;
        end else if (bus.i_en) begin
            s1_valid_q <= bus.i_valid;
            s1_mode_q  <= bus.i_length_mode;
            s1_x_q     <= bus.i_in_flat;
            s1_max_q   <= max_sel;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Stage 2: 17-bit subtract and saturate
    // -----------------------------------------------------------------------------------------
    logic [FW-1:0] sat_d;

    always_comb begin
        logic [DW:0] wide;
        sat_d = '0;
        wide  = '0;
        for (int k = 0; k < LANES; k++) begin
            wide = {s1_x_q[k*DW + DW - 1], s1_x_q[k*DW +: DW]}
                 - {s1_max_q[k*DW + DW - 1], s1_max_q[k*DW +: DW]};
            // The top two bits disagree only when the true difference leaves the DW-bit range.
            if (wide[DW] != wide[DW-1]) begin
                sat_d[k*DW +: DW] = wide[DW] ? SAT_MIN : SAT_MAX;
            end else begin
                sat_d[k*DW +: DW] = wide[DW-1:0];
            end
        end
    end

    logic          o_valid_q;
    logic [3:0]    o_mode_q;
    logic [FW-1:0] o_diff_q;

`ifdef MAXSUB_CLAMP_EN
    // -----------------------------------------------------------------------------------------
    // Optional clamp: very negative arguments give exp() == 0 downstream. Flag them so the exp
    // stage can skip them. Data and flag leave in the same cycle.
    // -----------------------------------------------------------------------------------------
    localparam logic signed [DW-1:0] CLAMP_Q = DW'(CLAMP_MIN);

    logic [FW-1:0]    diff_d;
    logic [LANES-1:0] mask_d;
    logic [LANES-1:0] o_mask_q;

    always_comb begin
        diff_d = sat_d;
        mask_d = '0;
        for (int k = 0; k < LANES; k++) begin
            if ($signed(sat_d[k*DW +: DW]) < CLAMP_Q) begin
                diff_d[k*DW +: DW] = CLAMP_Q;
                mask_d[k]          = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_mask_q <= '0;
        end else if (bus.i_en) begin
            o_mask_q <= mask_d;
        end
    end

    assign bus.o_zero_mask = o_mask_q;
`else
    logic [FW-1:0] diff_d;

    assign diff_d          = sat_d;
    assign bus.o_zero_mask = '0;
`endif

    // -----------------------------------------------------------------------------------------
    // Stage 2 registers (these drive the outputs directly)
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid_q <= 1'b0;
            o_mode_q  <= '0;
            o_diff_q  <= '0;
        end else if (bus.i_en) begin
            o_valid_q <= s1_valid_q;
            o_mode_q  <= s1_mode_q;
            o_diff_q  <= diff_d;
        end
    end

    assign bus.o_valid           = o_valid_q;
    assign bus.o_length_mode_byp = o_mode_q;
    assign bus.o_diff_flat       = o_diff_q;

endmodule

// File: tb/tb_max_subtract_stage.sv
// ---------------------------------------------------------------------------------------------
// tb_max_subtract_stage
//   Scoreboard bench. Stimulus pushes hand-computed expected beats, each tagged with the
//   cycle it must appear in. A monitor pops and compares them on every newly presented
//   o_valid. While a stall holds an output beat, the monitor checks that it stays unchanged.
// ---------------------------------------------------------------------------------------------
module tb_max_subtract_stage;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;

    always #5 i_clk = ~i_clk;

    max_subtract_stage_if bus ();

    max_subtract_stage dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [3:0]    mode;
        logic [1023:0] diff;
        logic [63:0]   mask;
        int            due;
    } exp_t;

    exp_t sb[$];
    exp_t last_e;
    bit   have_last = 1'b0;
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    bit   en_last   = 1'b0;

    always @(posedge i_clk) begin
        cyc     <= cyc + 1;
        en_last <= bus.i_en;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic chk_diff(input string name, input logic [1023:0] act,
                            input logic [1023:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            for (int k = 0; k < 64; k++) begin
                if (act[k*16 +: 16] !== req[k*16 +: 16]) begin
                    $display("FAIL %s lane %0d: got %h expected %h (cycle %0d)", name, k,
                             act[k*16 +: 16], req[k*16 +: 16], cyc);
                    break;
                end
            end
        end
    endtask

    // Monitor
    always @(negedge i_clk) begin
        exp_t e;
        if (i_rst_n && bus.o_valid) begin
            if (en_last) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got o_valid=1 expected no beat (cycle %0d)",
                             cyc);
                end else begin
                    e = sb.pop_front();
                    chk("latency_cycle", 64'(cyc), 64'(e.due));
                    chk("mode_byp", 64'(bus.o_length_mode_byp), 64'(e.mode));
                    chk_diff("diff", bus.o_diff_flat, e.diff);
                    chk("zero_mask", bus.o_zero_mask, e.mask);
                    last_e    = e;
                    have_last = 1'b1;
                end
            end else if (have_last) begin
                chk_diff("held_diff", bus.o_diff_flat, last_e.diff);
                chk("held_mode", 64'(bus.o_length_mode_byp), 64'(last_e.mode));
            end
        end
    end

    function automatic logic [1023:0] rep(input logic [15:0] v);
        logic [1023:0] r;
        for (int k = 0; k < 64; k++) r[k*16 +: 16] = v;
        return r;
    endfunction

    function automatic logic [1023:0] halves(input logic [15:0] lo, input logic [15:0] hi);
        logic [1023:0] r;
        for (int k = 0; k < 64; k++) r[k*16 +: 16] = (k < 32) ? lo : hi;
        return r;
    endfunction

    task automatic set_max(input logic [15:0] g, input logic [15:0] m64,
                           input logic [15:0] m32_0, input logic [15:0] m32_1,
                           input logic [15:0] m16_0, input logic [15:0] m16_1,
                           input logic [15:0] m16_2, input logic [15:0] m16_3);
        bus.i_global_max = g;
        bus.i_max64_0    = m64;
        bus.i_max32_0    = m32_0;
        bus.i_max32_1    = m32_1;
        bus.i_max16_0    = m16_0;
        bus.i_max16_1    = m16_1;
        bus.i_max16_2    = m16_2;
        bus.i_max16_3    = m16_3;
    endtask

    task automatic push(input logic [3:0] mode, input logic [1023:0] diff,
                        input logic [63:0] mask, input int extra);
        exp_t e;
        e.mode = mode;
        e.diff = diff;
        e.mask = mask;
        e.due  = cyc + 2 + extra;
        sb.push_back(e);
    endtask

    initial begin
        logic [1023:0] x;
        logic [1023:0] d;
        logic [15:0]   v;

        bus.i_en          = 1'b1;
        bus.i_valid       = 1'b0;
        bus.i_length_mode = '0;
        bus.i_in_flat     = '0;
        set_max(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);

        // Reset state
        @(negedge i_clk);
        @(negedge i_clk);
        chk("reset_valid", 64'(bus.o_valid), 64'd0);
        chk("reset_mode", 64'(bus.o_length_mode_byp), 64'd0);
        chk_diff("reset_diff", bus.o_diff_flat, '0);
        chk("reset_mask", bus.o_zero_mask, 64'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // 1: mode 0, every lane equals max64; other maxes are decoys
        bus.i_valid = 1'b1;
        bus.i_length_mode = 4'd0;
        bus.i_in_flat = rep(16'h0100);
        set_max(16'h7000, 16'h0100, 16'h7000, 16'h7000, 16'h7000, 16'h7000, 16'h7000, 16'h7000);
        push(4'd0, '0, 64'd0, 0);
        @(negedge i_clk);

        // 2: mode 1, separate halves
        bus.i_length_mode = 4'd1;
        bus.i_in_flat = halves(16'h0100, 16'h0200);
        set_max(16'h7000, 16'h7000, 16'h0100, 16'h0200, 16'h7000, 16'h7000, 16'h7000, 16'h7000);
        push(4'd1, '0, 64'd0, 0);
        @(negedge i_clk);

        // 3: mode 2, x[k]=k, max16_j=16j+15 -> d[k]=(k%16)-15
        bus.i_length_mode = 4'd2;
        for (int k = 0; k < 64; k++) begin
            x[k*16 +: 16] = 16'(k);
            v = 16'(k % 16) - 16'd15;
            d[k*16 +: 16] = v;
        end
        bus.i_in_flat = x;
        set_max(16'h7000, 16'h7000, 16'h7000, 16'h7000, 16'd15, 16'd31, 16'd47, 16'd63);
        push(4'd2, d, 64'd0, 0);
        @(negedge i_clk);

        // 4: mode 3, most negative minus most positive saturates
        bus.i_length_mode = 4'd3;
        bus.i_in_flat = rep(16'h8000);
        set_max(16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
`ifdef MAXSUB_CLAMP_EN
        push(4'd3, rep(16'hC000), {64{1'b1}}, 0);
`else
        push(4'd3, rep(16'h8000), 64'd0, 0);
`endif
        @(negedge i_clk);

        // Mode 15: positive d saturates high and is never flagged
        bus.i_length_mode = 4'd15;
        bus.i_in_flat = rep(16'h7FFF);
        set_max(16'h8000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        push(4'd15, rep(16'h7FFF), 64'd0, 0);
        @(negedge i_clk);

        // Clamp boundary: -16.0 exactly stays, one LSB below is clamped when enabled
        bus.i_length_mode = 4'd1;
        bus.i_in_flat = halves(16'hC000, 16'hBFFF);
        set_max(16'h7000, 16'h7000, 16'h0, 16'h0, 16'h7000, 16'h7000, 16'h7000, 16'h7000);
`ifdef MAXSUB_CLAMP_EN
        push(4'd1, rep(16'hC000), {{32{1'b1}}, 32'd0}, 0);
`else
        push(4'd1, halves(16'hC000, 16'hBFFF), 64'd0, 0);
`endif
        @(negedge i_clk);

        // Bubbles: data changes but no beat must appear
        bus.i_valid = 1'b0;
        bus.i_in_flat = rep(16'h1234);
        repeat (4) @(negedge i_clk);

        // 5a: beat in stage 1, then 3 stall cycles -> arrives 5 cycles after accept
        bus.i_valid = 1'b1;
        bus.i_length_mode = 4'd0;
        bus.i_in_flat = rep(16'h0300);
        set_max(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        push(4'd0, rep(16'h0300), 64'd0, 3);
        @(negedge i_clk);
        bus.i_en = 1'b0;
        bus.i_in_flat = rep(16'h0555);
        repeat (3) @(negedge i_clk);
        bus.i_en = 1'b1;
        bus.i_length_mode = 4'd2;
        bus.i_in_flat = rep(16'h0010);
        set_max(16'h0, 16'h0, 16'h0, 16'h0, 16'h0020, 16'h0010, 16'h0, 16'h0);
        d = '0;
        for (int k = 0; k < 64; k++) begin
            v = (k < 16) ? 16'hFFF0 : (k < 32) ? 16'h0000 : 16'h0010;
            d[k*16 +: 16] = v;
        end
        push(4'd2, d, 64'd0, 0);
        @(negedge i_clk);

        // 5b: two back-to-back beats, stall while the first is on the outputs
        bus.i_length_mode = 4'd0;
        bus.i_in_flat = rep(16'h0400);
        set_max(16'h0, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        push(4'd0, rep(16'h0300), 64'd0, 0);
        @(negedge i_clk);
        bus.i_length_mode = 4'd4;
        bus.i_in_flat = rep(16'h0000);
        set_max(16'h0400, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        push(4'd4, rep(16'hFC00), 64'd0, 2);
        @(negedge i_clk);
        bus.i_en = 1'b0;
        bus.i_valid = 1'b0;
        repeat (2) @(negedge i_clk);
        bus.i_en = 1'b1;
        repeat (3) @(negedge i_clk);

        // 6: reset while a beat sits in stage 1 and another is on the outputs
        bus.i_valid = 1'b1;
        bus.i_length_mode = 4'd0;
        bus.i_in_flat = rep(16'h0200);
        set_max(16'h0, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        push(4'd0, rep(16'h0100), 64'd0, 0);
        @(negedge i_clk);
        bus.i_length_mode = 4'd5;
        bus.i_in_flat = rep(16'h0600);
        @(negedge i_clk);
        bus.i_valid = 1'b0;
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(bus.o_valid), 64'd0);
        chk("rst_mid_mode", 64'(bus.o_length_mode_byp), 64'd0);
        chk_diff("rst_mid_diff", bus.o_diff_flat, '0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            chk("post_rst_no_valid", 64'(bus.o_valid), 64'd0);
        end

        // Pipeline works again after reset
        bus.i_valid = 1'b1;
        bus.i_length_mode = 4'd1;
        bus.i_in_flat = halves(16'h0000, 16'h0100);
        set_max(16'h0, 16'h0, 16'h0100, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0);
        push(4'd1, halves(16'hFF00, 16'h0100), 64'd0, 0);
        @(negedge i_clk);
        bus.i_valid = 1'b0;
        repeat (4) @(negedge i_clk);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
